hd44780_sequencer: RTL and testbench

Sequencer that drives the HD44780 character-output datapath and the LCD strobe pins. After reset it waits out LCD power-up, issues the four-command init sequence, then rewrites the clock line ("HH:MM:SS AM") on every update request. It sits between the clock counter (digit source) and `hd44780_data_output`, whose registered `o_q` feeds the LCD data bus. It generates that module's `i_ena`/`i_data`/`i_sel`/`i_d` controls plus LCD `E` and `RS`.

---
 rtl/hd44780_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_hd44780_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_sequencer.sv
// hd44780_sequencer
//
// Drives the HD44780 character-output datapath and the LCD strobe pins.
// After reset it waits out LCD power-up and issues the four init commands
// (0x34, 0x0C, 0x01, 0x06). It then redraws the clock line once
// automatically, and again on every i_update request.
//
// Each write is a LOAD / SETUP / EPULSE / WAIT sequence. LOAD drives the
// datapath controls for one cycle, so the datapath's registered o_q is valid
// from LOAD+1. E is high for E_PULSE_CYC cycles, starting SETUP_CYC cycles
// after o_q becomes valid.
//
// Configuration macro: HD44780_SEQ_SECONDS_EN
//   defined     -> 12-write refresh, "HH:MM:SS AM"
//   not defined -> 9-write refresh,  "HH:MM AM" (i_s10/i_s1 ignored)
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_update                single-cycle redraw request
//   i_h10..i_s1, i_pm       BCD time digits and the PM flag
//   o_ena/o_data/o_sel/o_d  datapath controls (non-zero only in LOAD)
//   o_lcd_e/o_lcd_rs/o_lcd_rw  LCD strobe, register select, read/write (always 0)
//   o_busy                  high whenever the sequencer is not in IDLE
//   o_init_done             sticky flag, set once the init sequence completes
module hd44780_sequencer #(
  parameter int         POWERUP_CYC  = 1_500_000,
  parameter int         SETUP_CYC    = 8,
  parameter int         E_PULSE_CYC  = 50,
  parameter int         CMD_WAIT_CYC = 5_000,
  parameter int         CLR_WAIT_CYC = 200_000,
  parameter logic [3:0] COL          = 4'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_update,
  input  logic [3:0] i_h10,
  input  logic [3:0] i_h1,
  input  logic [3:0] i_m10,
  input  logic [3:0] i_m1,
  input  logic [3:0] i_s10,
  input  logic [3:0] i_s1,
  input  logic       i_pm,
  output logic       o_ena,
  output logic       o_data,
  output logic [2:0] o_sel,
  output logic [3:0] o_d,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_busy,
  output logic       o_init_done
);

  typedef enum logic [2:0] {
    S_POWERUP, S_LOAD, S_SETUP, S_EPULSE, S_WAIT, S_IDLE
  } state_t;

  localparam logic [23:0] LIM_POWERUP = 24'(POWERUP_CYC - 1);
  localparam logic [23:0] LIM_SETUP   = 24'(SETUP_CYC - 1);
  localparam logic [23:0] LIM_EPULSE  = 24'(E_PULSE_CYC - 1);
  localparam logic [23:0] LIM_CMD     = 24'(CMD_WAIT_CYC - 1);
  localparam logic [23:0] LIM_CLR     = 24'(CLR_WAIT_CYC - 1);

`ifdef HD44780_SEQ_SECONDS_EN
  localparam logic [3:0] REF_LAST = 4'd11;
`else
  localparam logic [3:0] REF_LAST = 4'd8;
`endif

  state_t      state_q, state_d;
  logic [23:0] cnt_q;        // cycles spent in the current state
  logic [23:0] limit;
  logic        cnt_done;
  logic [3:0]  step_q;
  logic        init_q;       // 1 while the step index selects an init command
  logic        init_done_q;
  logic        rs_q;
  logic        pend_q;       // one-deep merged redraw request
  logic        last_step;
  logic        start_refresh;
  logic [3:0]  snap_h10, snap_h1, snap_m10, snap_m1;
  logic        snap_pm;
`ifdef HD44780_SEQ_SECONDS_EN
  logic [3:0]  snap_s10, snap_s1;
`else
  logic        unused_secs;
  assign unused_secs = ^{i_s10, i_s1};
`endif

  // Clear (init step 2) needs the long post-E wait.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    limit = '0;
    case (state_q)
      S_POWERUP: limit = LIM_POWERUP;
      S_SETUP:   limit = LIM_SETUP;
      S_EPULSE:  limit = LIM_EPULSE;
      S_WAIT:    limit = (init_q && step_q == 4'd2) ? LIM_CLR : LIM_CMD;
      default:   limit = '0;
    endcase
  end

  assign cnt_done  = (cnt_q == limit);
  assign last_step = init_q ? (step_q == 4'd3) : (step_q == REF_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!i_rst_n) state_q <= S_POWERUP;
    else          state_q <= state_d;
  end

  // Next-state logic. start_refresh marks entry into LOAD at refresh step 0.
  always_comb begin
    state_d       = state_q;
    start_refresh = 1'b0;
    case (state_q)
      S_POWERUP: if (cnt_done) state_d = S_LOAD;
      S_LOAD:    state_d = S_SETUP;
      S_SETUP:   if (cnt_done) state_d = S_EPULSE;
      S_EPULSE:  if (cnt_done) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_done) begin
          if (!last_step) begin
            state_d = S_LOAD;
          end else if (init_q || pend_q || i_update) begin
            // After init, or with a request pending, redraw without idling.
            state_d       = S_LOAD;
            start_refresh = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (i_update || pend_q) begin
          state_d       = S_LOAD;
          start_refresh = 1'b1;
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  // Counters, step index, flags and the digit snapshot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the snapshot is reset too; it is only a few flops and keeps reset state fully known.
      cnt_q       <= '0;
      step_q      <= '0;
      init_q      <= 1'b1;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      pend_q      <= 1'b0;
      snap_h10    <= '0;
      snap_h1     <= '0;
      snap_m10    <= '0;
      snap_m1     <= '0;
      snap_pm     <= 1'b0;
`ifdef HD44780_SEQ_SECONDS_EN
      snap_s10    <= '0;
      snap_s1     <= '0;
`endif
    end else begin
      cnt_q <= (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 24'd1;

      if (start_refresh) begin
        init_q   <= 1'b0;
        step_q   <= '0;
        snap_h10 <= i_h10;
        snap_h1  <= i_h1;
        snap_m10 <= i_m10;
        snap_m1  <= i_m1;
        snap_pm  <= i_pm;
`ifdef HD44780_SEQ_SECONDS_EN
        snap_s10 <= i_s10;
        snap_s1  <= i_s1;
`endif
      end else if (state_q == S_WAIT && cnt_done && !last_step) begin
        step_q <= step_q + 4'd1;
      end

      if (state_q == S_WAIT && cnt_done && init_q && last_step)
        init_done_q <= 1'b1;

      if (state_q == S_LOAD)
        rs_q <= o_data;

      // A request that coincides with the start of a redraw is served by it.
      if (start_refresh)
        pend_q <= 1'b0;
      else if (i_update && state_q != S_IDLE)
        pend_q <= 1'b1;
    end
  end

  // Output logic
  always_comb begin
    o_ena  = 1'b0;
    o_data = 1'b0;
    o_sel  = 3'b000;
    o_d    = 4'd0;
    if (state_q == S_LOAD) begin
      o_ena = 1'b1;
      if (init_q) begin
        o_sel = {1'b1, step_q[1:0]};
      end else begin
        o_data = 1'b1;
        case (step_q)
          4'd0: begin o_data = 1'b0; o_sel = 3'b000; o_d = COL; end
          4'd1: begin o_sel = 3'b000; o_d = snap_h10; end
          4'd2: begin o_sel = 3'b000; o_d = snap_h1;  end
          4'd3: begin o_sel = 3'b001; o_d = 4'd0;     end
          4'd4: begin o_sel = 3'b000; o_d = snap_m10; end
          4'd5: begin o_sel = 3'b000; o_d = snap_m1;  end
`ifdef HD44780_SEQ_SECONDS_EN
          4'd6:  begin o_sel = 3'b001; o_d = 4'd0;            end
          4'd7:  begin o_sel = 3'b000; o_d = snap_s10;        end
          4'd8:  begin o_sel = 3'b000; o_d = snap_s1;         end
          4'd9:  begin o_sel = 3'b001; o_d = 4'd1;            end
          4'd10: begin o_sel = 3'b011; o_d = {3'b0, snap_pm}; end
          4'd11: begin o_sel = 3'b010; o_d = 4'd0;            end
`else
          4'd6:  begin o_sel = 3'b001; o_d = 4'd1;            end
          4'd7:  begin o_sel = 3'b011; o_d = {3'b0, snap_pm}; end
          4'd8:  begin o_sel = 3'b010; o_d = 4'd0;            end
`endif
          default: begin o_data = 1'b0; o_sel = 3'b000; o_d = 4'd0; end
        endcase
      end
    end
  end

  assign o_lcd_e     = (state_q == S_EPULSE);
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_busy      = (state_q != S_IDLE);
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_hd44780_sequencer.sv
// Testbench for hd44780_sequencer. It models the downstream datapath byte
// encoding and logs every write, E edge and RS change against a cycle count
// measured from reset release.
`timescale 1ns/1ps
module tb_hd44780_sequencer;

  localparam int P_CYC = 20;
  localparam int S_CYC = 2;
  localparam int E_CYC = 3;
  localparam int C_CYC = 4;
  localparam int L_CYC = 10;

`ifdef HD44780_SEQ_SECONDS_EN
  localparam int N = 12;
  localparam logic [7:0] EXP_A [12] = '{8'h80, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34,
                                        8'h3A, 8'h35, 8'h36, 8'h20, 8'h50, 8'h4D};
  localparam logic [7:0] EXP_B [12] = '{8'h80, 8'h31, 8'h31, 8'h3A, 8'h35, 8'h39,
                                        8'h3A, 8'h34, 8'h37, 8'h20, 8'h41, 8'h4D};
`else
  localparam int N = 9;
  localparam logic [7:0] EXP_A [9] = '{8'h80, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34,
                                       8'h20, 8'h50, 8'h4D};
  localparam logic [7:0] EXP_B [9] = '{8'h80, 8'h31, 8'h31, 8'h3A, 8'h35, 8'h39,
                                       8'h20, 8'h41, 8'h4D};
`endif
  localparam logic [7:0] EXP_INIT [4] = '{8'h34, 8'h0C, 8'h01, 8'h06};
  localparam int         EXP_GAP  [4] = '{10, 10, 16, 10};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       upd = 1'b0;
  logic [3:0] h10 = 4'd1, h1 = 4'd2, m10 = 4'd3, m1 = 4'd4, s10 = 4'd5, s1 = 4'd6;
  logic       pm = 1'b1;
  logic       o_ena, o_data, o_lcd_e, o_lcd_rs, o_lcd_rw, o_busy, o_init_done;
  logic [2:0] o_sel;
  logic [3:0] o_d;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  hd44780_sequencer #(
    .POWERUP_CYC (P_CYC),
    .SETUP_CYC   (S_CYC),
    .E_PULSE_CYC (E_CYC),
    .CMD_WAIT_CYC(C_CYC),
    .CLR_WAIT_CYC(L_CYC),
    .COL         (4'd0)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_update   (upd),
    .i_h10      (h10),
    .i_h1       (h1),
    .i_m10      (m10),
    .i_m1       (m1),
    .i_s10      (s10),
    .i_s1       (s1),
    .i_pm       (pm),
    .o_ena      (o_ena),
    .o_data     (o_data),
    .o_sel      (o_sel),
    .o_d        (o_d),
    .o_lcd_e    (o_lcd_e),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_busy     (o_busy),
    .o_init_done(o_init_done)
  );

  // Byte the downstream datapath registers for a given set of controls.
  function automatic logic [7:0] q_of(input logic data, input logic [2:0] sel,
                                      input logic [3:0] d);
    if (!data) begin
      case (sel)
        3'b000:  return {4'h8, d};
        3'b100:  return 8'h34;
        3'b101:  return 8'h0C;
        3'b110:  return 8'h01;
        3'b111:  return 8'h06;
        default: return 8'h00;
      endcase
    end
    case (sel[1:0])
      2'b00:   return 8'h30 + {4'h0, d};
      2'b01:   return d[0] ? 8'h20 : 8'h3A;
      2'b10:   return 8'h4D;
      default: return d[0] ? 8'h50 : 8'h41;
    endcase
  endfunction

  // Cycle count and write/strobe log
  int cyc = 0;
  int rel_base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wr_byte [$];
  int         wr_cyc  [$];
  bit         rs_after[$];
  int         e_rise  [$];
  int         e_fall  [$];
  int         rs_chg  [$];
  int         done_rise = -1;
  int         idle_cyc  = 0;
  bit ena_prev = 0, e_prev = 0, rs_prev = 0, done_prev = 0;

  always @(negedge clk) begin
    int t;
    t = cyc - rel_base;
    if (o_ena) begin
      wr_byte.push_back(q_of(o_data, o_sel, o_d));
      wr_cyc.push_back(t);
    end
    if (ena_prev) rs_after.push_back(o_lcd_rs);
    if (o_lcd_e && !e_prev) e_rise.push_back(t);
    if (!o_lcd_e && e_prev) e_fall.push_back(t);
    if (o_lcd_rs != rs_prev) rs_chg.push_back(t);
    if (o_init_done && !done_prev) done_rise = t;
    if (!o_busy) idle_cyc++;
    ena_prev  = o_ena;
    e_prev    = o_lcd_e;
    rs_prev   = o_lcd_rs;
    done_prev = o_init_done;
  end

  task automatic clear_log();
    wr_byte.delete(); wr_cyc.delete(); rs_after.delete();
    e_rise.delete();  e_fall.delete(); rs_chg.delete();
    done_rise = -1;
    idle_cyc  = 0;
  endtask

  task automatic pulse_update();
    @(negedge clk); upd = 1'b1;
    @(negedge clk); upd = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!o_busy) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  function automatic logic [7:0] byte_at(input int i);
    return (i < wr_byte.size()) ? wr_byte[i] : 8'hxx;
  endfunction

  // Reset values, then release with a redraw request during POWERUP
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({o_ena, o_data, o_sel, o_d} !== 9'd0) $display("FAIL reset_ctrl got %h want 0", {o_ena, o_data, o_sel, o_d}); else pass_cnt++;
    chk_cnt++; if ({o_lcd_e, o_lcd_rs, o_lcd_rw} !== 3'b000) $display("FAIL reset_lcd got %b want 000", {o_lcd_e, o_lcd_rs, o_lcd_rw}); else pass_cnt++;
    chk_cnt++; if (o_busy !== 1'b1) $display("FAIL reset_busy got %b want 1", o_busy); else pass_cnt++;
    chk_cnt++; if (o_init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", o_init_done); else pass_cnt++;
    clear_log();
    @(negedge clk);
    rst_n    = 1'b1;
    rel_base = cyc;
    repeat (4) @(negedge clk);
    pulse_update();
  endtask

  task automatic test_init();
    bit ok;
    wait_idle(2000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL init_timeout got busy=%b want idle", o_busy); else pass_cnt++;
    chk_cnt++; if (wr_byte.size() !== 4 + N) $display("FAIL init_write_count got %0d want %0d", wr_byte.size(), 4 + N); else pass_cnt++;
    chk_cnt++; if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) !== P_CYC) $display("FAIL first_ena_cycle got %0d want %0d", wr_cyc.size() > 0 ? wr_cyc[0] : -1, P_CYC); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (byte_at(i) !== EXP_INIT[i]) $display("FAIL init_byte[%0d] got %h want %h", i, byte_at(i), EXP_INIT[i]); else pass_cnt++;
      if (wr_cyc.size() > i + 1) begin
        chk_cnt++; if (wr_cyc[i+1] - wr_cyc[i] !== EXP_GAP[i]) $display("FAIL init_gap[%0d] got %0d want %0d", i, wr_cyc[i+1] - wr_cyc[i], EXP_GAP[i]); else pass_cnt++;
      end
    end
    chk_cnt++; if (done_rise !== 66) $display("FAIL init_done_cycle got %0d want 66", done_rise); else pass_cnt++;
  endtask

  // Automatic redraw after init: "12:34:56 PM" / "12:34 PM"
  task automatic test_redraw();
    for (int i = 0; i < N; i++) begin
      chk_cnt++; if (byte_at(4 + i) !== EXP_A[i]) $display("FAIL redraw_byte[%0d] got %h want %h", i, byte_at(4 + i), EXP_A[i]); else pass_cnt++;
      if (rs_after.size() > 4 + i) begin
        chk_cnt++; if (rs_after[4 + i] !== (i != 0)) $display("FAIL redraw_rs[%0d] got %b want %b", i, rs_after[4 + i], i != 0); else pass_cnt++;
      end
    end
    chk_cnt++; if (o_busy !== 1'b0) $display("FAIL redraw_busy got %b want 0", o_busy); else pass_cnt++;
    repeat (40) @(negedge clk);
    chk_cnt++; if (wr_byte.size() !== 4 + N) $display("FAIL powerup_request_merged got %0d writes want %0d", wr_byte.size(), 4 + N); else pass_cnt++;
  endtask

  // E placement per write, RS changes only at LOAD+1
  task automatic test_timing();
    bit hit;
    chk_cnt++; if (e_rise.size() !== wr_cyc.size()) $display("FAIL e_pulse_count got %0d want %0d", e_rise.size(), wr_cyc.size()); else pass_cnt++;
    for (int i = 0; i < wr_cyc.size() && i < e_rise.size() && i < e_fall.size(); i++) begin
      chk_cnt++; if (e_rise[i] !== wr_cyc[i] + 1 + S_CYC) $display("FAIL e_rise[%0d] got %0d want %0d", i, e_rise[i], wr_cyc[i] + 1 + S_CYC); else pass_cnt++;
      chk_cnt++; if (e_fall[i] - e_rise[i] !== E_CYC) $display("FAIL e_width[%0d] got %0d want %0d", i, e_fall[i] - e_rise[i], E_CYC); else pass_cnt++;
    end
    chk_cnt++; if (rs_chg.size() !== 1) $display("FAIL rs_change_count got %0d want 1", rs_chg.size()); else pass_cnt++;
    foreach (rs_chg[k]) begin
      hit = 1'b0;
      foreach (wr_cyc[j]) if (rs_chg[k] == wr_cyc[j] + 1) hit = 1'b1;
      chk_cnt++; if (hit !== 1'b1) $display("FAIL rs_change_at_load1 got cycle %0d want a LOAD+1 cycle", rs_chg[k]); else pass_cnt++;
    end
  endtask

  // Digits change mid-refresh; output must follow the snapshot
  task automatic test_snapshot();
    bit ok;
    clear_log();
    h10 = 4'd1; h1 = 4'd1; m10 = 4'd5; m1 = 4'd9; s10 = 4'd4; s1 = 4'd7; pm = 1'b0;
    pulse_update();
    repeat (15) @(negedge clk);
    h10 = 4'd0; h1 = 4'd0; m10 = 4'd0; m1 = 4'd0; s10 = 4'd0; s1 = 4'd0; pm = 1'b1;
    wait_idle(1000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL snapshot_timeout got busy=%b want idle", o_busy); else pass_cnt++;
    chk_cnt++; if (wr_byte.size() !== N) $display("FAIL snapshot_count got %0d want %0d", wr_byte.size(), N); else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      chk_cnt++; if (byte_at(i) !== EXP_B[i]) $display("FAIL snapshot_byte[%0d] got %h want %h", i, byte_at(i), EXP_B[i]); else pass_cnt++;
    end
  endtask

  // Three requests during a refresh merge into one back-to-back refresh
  task automatic test_back_to_back();
    bit ok;
    clear_log();
    h10 = 4'd1; h1 = 4'd2; m10 = 4'd3; m1 = 4'd4; s10 = 4'd5; s1 = 4'd6; pm = 1'b1;
    pulse_update();
    idle_cyc = 0;
    repeat (5) @(negedge clk);
    pulse_update();
    repeat (25) @(negedge clk);
    pulse_update();
    repeat (30) @(negedge clk);
    pulse_update();
    wait_idle(2000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL b2b_timeout got busy=%b want idle", o_busy); else pass_cnt++;
    chk_cnt++; if (idle_cyc !== 1) $display("FAIL b2b_idle_cycles got %0d want 1", idle_cyc); else pass_cnt++;
    chk_cnt++; if (wr_byte.size() !== 2 * N) $display("FAIL b2b_count got %0d want %0d", wr_byte.size(), 2 * N); else pass_cnt++;
    if (wr_cyc.size() > N) begin
      chk_cnt++; if (wr_cyc[N] - wr_cyc[N-1] !== 1 + S_CYC + E_CYC + C_CYC) $display("FAIL b2b_gap got %0d want %0d", wr_cyc[N] - wr_cyc[N-1], 1 + S_CYC + E_CYC + C_CYC); else pass_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      chk_cnt++; if (byte_at(N + i) !== EXP_A[i]) $display("FAIL b2b_byte[%0d] got %h want %h", i, byte_at(N + i), EXP_A[i]); else pass_cnt++;
    end
    repeat (40) @(negedge clk);
    chk_cnt++; if (wr_byte.size() !== 2 * N) $display("FAIL b2b_no_third got %0d want %0d", wr_byte.size(), 2 * N); else pass_cnt++;
  endtask

  // Reset while E is high: E drops at once and init replays
  task automatic test_reset_mid_write();
    bit ok, seen;
    pulse_update();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_lcd_e) begin seen = 1'b1; break; end
    end
    chk_cnt++; if (seen !== 1'b1) $display("FAIL mid_e_seen got %b want 1", seen); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (o_lcd_e !== 1'b0) $display("FAIL mid_e_drop got %b want 0", o_lcd_e); else pass_cnt++;
    chk_cnt++; if (o_init_done !== 1'b0) $display("FAIL mid_init_done got %b want 0", o_init_done); else pass_cnt++;
    @(negedge clk);
    clear_log();
    @(negedge clk);
    rst_n    = 1'b1;
    rel_base = cyc;
    wait_idle(2000, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL replay_timeout got busy=%b want idle", o_busy); else pass_cnt++;
    chk_cnt++; if (wr_byte.size() !== 4 + N) $display("FAIL replay_count got %0d want %0d", wr_byte.size(), 4 + N); else pass_cnt++;
    chk_cnt++; if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) !== P_CYC) $display("FAIL replay_first_ena got %0d want %0d", wr_cyc.size() > 0 ? wr_cyc[0] : -1, P_CYC); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (byte_at(i) !== EXP_INIT[i]) $display("FAIL replay_init[%0d] got %h want %h", i, byte_at(i), EXP_INIT[i]); else pass_cnt++;
    end
    for (int i = 0; i < N; i++) begin
      chk_cnt++; if (byte_at(4 + i) !== EXP_A[i]) $display("FAIL replay_redraw[%0d] got %h want %h", i, byte_at(4 + i), EXP_A[i]); else pass_cnt++;
    end
    chk_cnt++; if (done_rise !== 66) $display("FAIL replay_done_cycle got %0d want 66", done_rise); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_redraw();
    test_timing();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
